// File: rtl/echo_pipeline_sequencer_pkg.sv
// Shared types and default timing for the echo-cancellation chain controllers.
// Holds the sequencer state encoding and the timing constants other controllers reuse.
package echo_pkg;

    localparam int CNT_W_DEF     = 13;
    localparam int PULSE_LEN_DEF = 2;
    localparam int CONV_WAIT_DEF = 8;
    localparam int LAG_WAIT_DEF  = 600;

    typedef enum logic [2:0] {
        IDLE,
        CONV_EN,
        CONV_WT,
        LAG_EN,
        LAG_WT,
        D2S_EN
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/echo_pipeline_sequencer_if.sv
// Bus between the sequencer and the echo chain: frame counter, ready flags, enables, stats.
// master = the sequencer, slave = the chain side.
interface echo_pipeline_sequencer_if
    import echo_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STAT_W = 8
);
    logic [CNT_W-1:0]  sampling_cycle_counter;
    logic              ready_conv;
    logic              ready_lag;
    logic              enable_conv;
    logic              enable_lag;
    logic              enable_d2s;
    logic              enable_sampling;
    logic              enable_cancel;
    logic              busy;
    logic [STAT_W-1:0] miss_cnt;
    logic [STAT_W-1:0] overrun_cnt;

    modport master (
        input  sampling_cycle_counter, ready_conv, ready_lag,
        output enable_conv, enable_lag, enable_d2s, enable_sampling,
        output enable_cancel, busy, miss_cnt, overrun_cnt
    );

    modport slave (
        output sampling_cycle_counter, ready_conv, ready_lag,
        input  enable_conv, enable_lag, enable_d2s, enable_sampling,
        input  enable_cancel, busy, miss_cnt, overrun_cnt
    );
endinterface

// File: rtl/echo_pipeline_sequencer_sat.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = (1 << WIDTH) - 1
)(
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] value_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            value_reg <= '0;
        end else if (inc && (value_reg != MAX_V)) begin
            value_reg <= value_reg + WIDTH'(1);
        end
    end

    assign value = value_reg;
endmodule

// File: rtl/echo_pipeline_sequencer.sv
// Per-frame enable sequencer: conv pulse, wait, lag pulse, wait, d2s pulse, gated on ready flags.
// Also produces the lag_generator warm-up gate and the sticky canceller enable.
module echo_pipeline_sequencer
    import echo_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int PULSE_LEN     = PULSE_LEN_DEF,
    parameter int CONV_WAIT     = CONV_WAIT_DEF,
    parameter int LAG_WAIT      = LAG_WAIT_DEF,
    parameter int WARMUP_FRAMES = 2,
    parameter int STAT_W        = 8
)(
    input  logic                      clk_operation,
    input  logic                      rst,
    echo_pipeline_sequencer_if.master bus
);
    localparam int TMR_MAX = max3(PULSE_LEN, CONV_WAIT, LAG_WAIT);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FRM_W   = (WARMUP_FRAMES < 1) ? 1 : $clog2(WARMUP_FRAMES + 1);

    // Timer counts down to zero, so each state is loaded with its length minus one.
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_LEN - 1);
    localparam logic [TMR_W-1:0] CONV_LD  = TMR_W'(CONV_WAIT - 1);
    localparam logic [TMR_W-1:0] LAG_LD   = TMR_W'(LAG_WAIT - 1);

    seq_state_t        state_reg, state_next;
    logic [TMR_W-1:0]  tmr_reg, tmr_next;
    logic [CNT_W-1:0]  prev_reg;
    logic              enable_conv_reg, enable_lag_reg, enable_d2s_reg;
    logic              enable_cancel_reg, busy_reg;
    logic              fs, tmr_done, miss_inc, overrun_inc;
    logic [1:0]        stat_inc;
    logic [STAT_W-1:0] stat_val [2];
    logic [FRM_W-1:0]  frame_cnt;

    assign fs          = (bus.sampling_cycle_counter == '0) && (prev_reg != '0);
    assign tmr_done    = (tmr_reg == '0);
    assign overrun_inc = fs && (state_reg != IDLE);

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state_reg         <= IDLE;
            tmr_reg           <= '0;
            prev_reg          <= '0;
            enable_conv_reg   <= 1'b0;
            enable_lag_reg    <= 1'b0;
            enable_d2s_reg    <= 1'b0;
            enable_cancel_reg <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            tmr_reg           <= tmr_next;
            prev_reg          <= bus.sampling_cycle_counter;
            enable_conv_reg   <= (state_next == CONV_EN);
            enable_lag_reg    <= (state_next == LAG_EN);
            enable_d2s_reg    <= (state_next == D2S_EN);
            enable_cancel_reg <= enable_cancel_reg | (state_next == D2S_EN);
            busy_reg          <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        miss_inc   = 1'b0;
        case (state_reg)
            IDLE:    if (fs) state_next = CONV_EN;
            CONV_EN: if (tmr_done) state_next = CONV_WT;
            CONV_WT: if (tmr_done) begin
                         if (bus.ready_conv) state_next = LAG_EN;
                         else begin
                             state_next = IDLE;
                             miss_inc   = 1'b1;
                         end
                     end
            LAG_EN:  if (tmr_done) state_next = LAG_WT;
            LAG_WT:  if (tmr_done) begin
                         if (bus.ready_lag) state_next = D2S_EN;
                         else begin
                             state_next = IDLE;
                             miss_inc   = 1'b1;
                         end
                     end
            D2S_EN:  if (tmr_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        tmr_next = tmr_done ? tmr_reg : tmr_reg - TMR_W'(1);
        if (state_next != state_reg) begin
            case (state_next)
                CONV_EN, LAG_EN, D2S_EN: tmr_next = PULSE_LD;
                CONV_WT:                 tmr_next = CONV_LD;
                LAG_WT:                  tmr_next = LAG_LD;
                default:                 tmr_next = '0;
            endcase
        end
    end

    // Index 0 counts aborted frames, index 1 counts frame starts that arrived while busy.
    assign stat_inc = {overrun_inc, miss_inc};

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        sat_counter #(.WIDTH(STAT_W)) u_stat (
            .clk   (clk_operation),
            .clr   (rst),
            .inc   (stat_inc[gi]),
            .value (stat_val[gi])
        );
    end

    sat_counter #(.WIDTH(FRM_W), .MAX(WARMUP_FRAMES)) u_frames (
        .clk   (clk_operation),
        .clr   (rst),
        .inc   (fs),
        .value (frame_cnt)
    );

    assign bus.enable_conv     = enable_conv_reg;
    assign bus.enable_lag      = enable_lag_reg;
    assign bus.enable_d2s      = enable_d2s_reg;
    assign bus.enable_cancel   = enable_cancel_reg;
    assign bus.busy            = busy_reg;
    assign bus.enable_sampling = (frame_cnt == FRM_W'(WARMUP_FRAMES));
    assign bus.miss_cnt        = stat_val[0];
    assign bus.overrun_cnt     = stat_val[1];
endmodule

// File: tb/tb_echo_pipeline_sequencer.sv
// Scoreboard bench: stimulus process predicts per-cycle outputs from the frame schedule,
// monitor process compares them against the sequencer on the falling edge.
module tb_echo_pipeline_sequencer;
    localparam int CNT_W = 13;
    localparam int STAT_W = 8;
    localparam int P = 2;
    localparam int CW = 8;
    localparam int LW = 20;
    localparam int WARM = 2;
    localparam int SMAX = 255;

    typedef struct packed {
        logic       conv;
        logic       lag;
        logic       d2s;
        logic       samp;
        logic       cancel;
        logic       busy;
        logic [7:0] miss;
        logic [7:0] ovr;
    } exp_t;

    typedef struct {
        int   cyc;
        exp_t v;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];

    // Reference model: one frame schedule described by its start cycle and (possibly cut) end cycle.
    bit m_have;
    int m_t, m_end, m_prev, m_miss, m_ovr, m_frames;
    bit m_cancel;

    echo_pipeline_sequencer_if #(.CNT_W(CNT_W), .STAT_W(STAT_W)) bus ();

    echo_pipeline_sequencer #(
        .CNT_W(CNT_W), .PULSE_LEN(P), .CONV_WAIT(CW), .LAG_WAIT(LW),
        .WARMUP_FRAMES(WARM), .STAT_W(STAT_W)
    ) dut (
        .clk_operation (clk),
        .rst           (rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic bit in_win(input int n, input int lo, input int hi);
        return (n >= lo) && (n <= hi);
    endfunction

    function automatic bit rdy(input int mode);
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return (mode == 1);
    endfunction

    task automatic step(input bit r, input int cnt, input bit rc, input bit rl);
        exp_t e;
        int c, n;
        bit fs, active;
        c = cyc;
        rst = r;
        bus.sampling_cycle_counter = CNT_W'(cnt);
        bus.ready_conv = rc;
        bus.ready_lag = rl;
        if (r) begin
            m_have = 0; m_prev = 0; m_miss = 0; m_ovr = 0; m_frames = 0; m_cancel = 0;
        end else begin
            fs = (cnt == 0) && (m_prev != 0);
            if (m_have && c <= m_end) begin
                if (c == m_t + P + CW && !rc) begin
                    m_end = c;
                    if (m_miss < SMAX) m_miss++;
                end else if (c == m_t + 2*P + CW + LW && !rl) begin
                    m_end = c;
                    if (m_miss < SMAX) m_miss++;
                end
            end
            active = m_have && in_win(c, m_t + 1, m_end);
            if (fs) begin
                if (m_frames < WARM) m_frames++;
                if (active) begin
                    if (m_ovr < SMAX) m_ovr++;
                end else begin
                    m_have = 1;
                    m_t = c;
                    m_end = c + 3*P + CW + LW;
                end
            end
            m_prev = cnt;
        end
        n = c + 1;
        e.busy = m_have && in_win(n, m_t + 1, m_end);
        e.conv = e.busy && in_win(n, m_t + 1, m_t + P);
        e.lag  = e.busy && in_win(n, m_t + P + CW + 1, m_t + 2*P + CW);
        e.d2s  = e.busy && in_win(n, m_t + 2*P + CW + LW + 1, m_t + 3*P + CW + LW);
        if (e.d2s) m_cancel = 1;
        e.cancel = m_cancel;
        e.samp = (m_frames >= WARM);
        e.miss = 8'(m_miss);
        e.ovr = 8'(m_ovr);
        sb.push_back('{cyc: n, v: e});
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int period, input int nfr, input int rcm, input int rlm, input int hold);
        for (int f = 0; f < nfr; f++) begin
            for (int k = 1; k < period; k++) step(0, k, rdy(rcm), rdy(rlm));
            for (int h = 0; h <= hold; h++) step(0, 0, rdy(rcm), rdy(rlm));
        end
    endtask

    always @(negedge clk) begin
        sb_t  s;
        exp_t got;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            s = sb.pop_front();
            got = {bus.enable_conv, bus.enable_lag, bus.enable_d2s, bus.enable_sampling,
                   bus.enable_cancel, bus.busy, bus.miss_cnt, bus.overrun_cnt};
            checks++;
            if (got !== s.v) begin
                errors++;
                $display("FAIL outputs cyc=%0d got conv=%b lag=%b d2s=%b samp=%b cancel=%b busy=%b miss=%0d ovr=%0d want conv=%b lag=%b d2s=%b samp=%b cancel=%b busy=%b miss=%0d ovr=%0d",
                         cyc, got.conv, got.lag, got.d2s, got.samp, got.cancel, got.busy, got.miss, got.ovr,
                         s.v.conv, s.v.lag, s.v.d2s, s.v.samp, s.v.cancel, s.v.busy, s.v.miss, s.v.ovr);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.sampling_cycle_counter = '0;
        bus.ready_conv = 1'b0;
        bus.ready_lag = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

        // Warm-up with a held zero, lag miss, clean frame, conv miss, clean frame.
        run(100, 1, 1, 1, 5);
        run(100, 1, 1, 0, 0);
        run(100, 1, 1, 1, 0);
        run(100, 1, 0, 1, 0);
        run(100, 1, 1, 1, 0);

        // Period shorter than the sequence: every second frame is an overrun.
        run(30, 6, 1, 1, 0);

        for (int i = 0; i < 20; i++)
            run($urandom_range(8, 120), 1, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));

        // Frame start every second cycle drives the overrun counter into saturation.
        for (int i = 0; i < 350; i++) begin
            step(0, 1, 1, 1);
            step(0, 0, 1, 1);
        end
        checks++;
        if (bus.overrun_cnt !== 8'd255) begin
            errors++;
            $display("FAIL overrun_sat got %0d want 255", bus.overrun_cnt);
        end

        // Reset while in the lag wait, then clean frames with a fresh warm-up.
        run(100, 1, 1, 1, 0);
        for (int k = 1; k <= 20; k++) step(0, k, 1, 1);
        step(1, 21, 1, 1);
        run(100, 3, 1, 1, 0);
        for (int k = 1; k < 5; k++) step(0, k, 1, 1);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
